// File: rtl/vga_line_doubler.sv
// rtl/vga_line_doubler.sv - PPU line capture into ping-pong RAM, replayed twice per source line as 640x480@60 VGA.
// Optional VGA_SCANLINE_EN halves the intensity of the second VGA line of each pair.
module vga_line_doubler #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_PULSE  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_BACK_PORCH  = 32,
  parameter int START_DELAY   = 3201
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        pix_we,
  input  logic [23:0] pix_data,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        wr_overflow
);

  localparam int SW = $clog2(START_DELAY + 1);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT_PORCH);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT_PORCH);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE);
  localparam logic [SW-1:0] START_LAST = SW'(START_DELAY - 1);

  logic [23:0]   mem [0:2047];
  logic [23:0]   rd_data;
  logic          wr_bank, rd_bank;
  logic [10:0]   wr_addr;
  logic          new_line, wr_bank_eff, wr_en;
  logic [9:0]    wr_idx;
  logic          armed, vga_run, start_done;
  logic [SW-1:0] start_cnt;
  logic [9:0]    h_cnt, v_cnt;
  logic          s1_blank, s1_hsync, s1_vsync, s1_odd;
  logic [23:0]   pix_out;

  // The bank being filled this clk, including the one a same-clk line_start switches to.
  assign new_line    = frame_start | line_start;
  assign wr_bank_eff = new_line ? ~wr_bank : wr_bank;
  assign wr_idx      = new_line ? 10'd0 : wr_addr[9:0];
  assign wr_en       = pix_we & (new_line | ~wr_addr[10]);
  assign start_done  = armed & ~vga_run & (start_cnt == START_LAST);

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank_eff, wr_idx}] <= pix_data;
    rd_data <= mem[{rd_bank, h_cnt}];
  end

  // wr_addr reaching 1024 means the line is full; further writes only raise the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank     <= 1'b0;
      wr_addr     <= 11'd0;
      wr_overflow <= 1'b0;
    end else if (new_line) begin
      wr_bank <= ~wr_bank;
      wr_addr <= {10'd0, pix_we};
    end else if (pix_we) begin
      if (wr_addr[10]) wr_overflow <= 1'b1;
      else             wr_addr     <= wr_addr + 11'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed     <= 1'b0;
      vga_run   <= 1'b0;
      start_cnt <= '0;
    end else if (!vga_run) begin
      if (armed) begin
        if (start_done) vga_run <= 1'b1;
        start_cnt <= start_cnt + 1'b1;
      end else if (frame_start) begin
        armed     <= 1'b1;
        start_cnt <= SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt   <= 10'd0;
      v_cnt   <= 10'd0;
      rd_bank <= 1'b0;
    end else begin
      if (start_done) rd_bank <= ~wr_bank_eff;
      if (vga_run) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= 10'd0;
          v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
          if (v_cnt[0] || v_cnt == V_LAST) rd_bank <= ~wr_bank_eff;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_blank <= 1'b1;
      s1_hsync <= 1'b1;
      s1_vsync <= 1'b1;
      s1_odd   <= 1'b0;
    end else begin
      s1_blank <= ~(vga_run && h_cnt < H_VIS && v_cnt < V_VIS);
      s1_hsync <= ~(vga_run && h_cnt >= HS_BEG && h_cnt < HS_END);
      s1_vsync <= ~(vga_run && v_cnt >= VS_BEG && v_cnt < VS_END);
      s1_odd   <= vga_run & v_cnt[0];
    end
  end

  always_comb begin
    pix_out = s1_blank ? 24'd0 : rd_data;
`ifdef VGA_SCANLINE_EN
    if (s1_odd) pix_out = (pix_out >> 1) & 24'h7F7F7F;
`else
    if (s1_odd) pix_out = pix_out;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red   <= 8'd0;
      green <= 8'd0;
      blue  <= 8'd0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank <= 1'b1;
    end else begin
      red   <= pix_out[7:0];
      green <= pix_out[15:8];
      blue  <= pix_out[23:16];
      hsync <= s1_hsync;
      vsync <= s1_vsync;
      blank <= s1_blank;
    end
  end

endmodule

// File: tb/tb_vga_line_doubler.sv
// tb/tb_vga_line_doubler.sv - random line data against a frame-timing reference model for vga_line_doubler.
module tb_vga_line_doubler;

  localparam int VV = 8, VFP = 2, VSP = 2, VBP = 3;
  localparam int VT = VV + VFP + VSP + VBP;
  localparam int LAT = 3201 + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0, line_start = 1'b0, pix_we = 1'b0;
  logic [23:0] pix_data = 24'd0;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, blank, wr_overflow;

  int n_assert = 0, n_fail = 0;
  logic [23:0] src [0:15][0:639];
  int wcnt [0:15];
  int hs_low, vs_low, blk_cnt;

  vga_line_doubler #(
    .V_VISIBLE(VV), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .pix_we(pix_we), .pix_data(pix_data), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .blank(blank), .wr_overflow(wr_overflow)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic init_src();
    for (int n = 0; n < 16; n++) begin
      wcnt[n] = 0;
      for (int i = 0; i < 640; i++)
        src[n][i] = (n == 2) ? 24'hFEFEFE : 24'($urandom);
    end
    src[3][0] = 24'h123456;
  endtask

  task automatic drive(input logic ls, input logic we, input logic [23:0] d);
    @(posedge clk); #1;
    frame_start = 1'b0; line_start = ls; pix_we = we; pix_data = d;
  endtask

  // Cycle 0 carries frame_start; source line n starts at 1600*n. VGA pair k replays source line k+1.
  task automatic run(input int ncyc);
    int n, o, n2, h, ln, v;
    logic blk, hs, vs;
    logic [23:0] p;
    logic [26:0] obs, exp;
    hs_low = 0; vs_low = 0; blk_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      n = c / 1600; o = c % 1600;
      frame_start = (c == 0 || c == 4800);
      line_start  = (o == 0) && !frame_start;
      pix_we = 1'b0;
      if (n < 16 && wcnt[n] < 640 && (o == 0 || $urandom_range(3) != 0)) begin
        pix_we = 1'b1; pix_data = src[n][wcnt[n]]; wcnt[n]++;
      end
      @(negedge clk);
      obs = {blue, green, red, hsync, vsync, blank};
      if (c < LAT) begin
        check("reset_hold", 32'(obs), 32'({24'd0, 3'b111}));
      end else begin
        n2 = c - LAT; h = n2 % 800; ln = n2 / 800; v = ln % VT;
        blk = !(h < 640 && v < VV);
        hs  = !(h >= 656 && h < 752);
        vs  = !(v >= VV + VFP && v < VV + VFP + VSP);
        p = 24'd0;
        if (!blk && ln < VT) begin
          p = src[v / 2 + 1][h];
`ifdef VGA_SCANLINE_EN
          if (v % 2 == 1) p = (p >> 1) & 24'h7F7F7F;
`endif
        end
        exp = {p, hs, vs, blk};
        if (ln < VT || blk) check("video", 32'(obs), 32'(exp));
        else                check("sync_f2", 32'(obs[2:0]), 32'(exp[2:0]));
        if (ln < VT) begin
          hs_low  += int'(!hsync);
          vs_low  += int'(!vsync);
          blk_cnt += int'(blank);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", 32'({blue, green, red, hsync, vsync, blank, wr_overflow}), 32'({24'd0, 4'b1110}));
    @(posedge clk); #1; rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("idle_no_frame", 32'({blue, green, red, hsync, vsync, blank}), 32'({24'd0, 3'b111}));
    end

    init_src();
    run(LAT + 16 * 800);
    check("hsync_low_frame", 32'(hs_low), 32'(VT * 96));
    check("vsync_low_frame", 32'(vs_low), 32'(VSP * 800));
    check("blank_frame", 32'(blk_cnt), 32'(VT * 160 + (VT - VV) * 640));

    // Land in the clk where h_cnt=300 of a visible line, then reset asynchronously.
    frame_start = 1'b0; line_start = 1'b0; pix_we = 1'b0;
    repeat (300 - 2 + 1) @(posedge clk);
    #1;
    check("pre_rst_visible", 32'(blank), 32'd0);
    rst = 1'b1;
    #1;
    check("async_rst", 32'({blue, green, red, hsync, vsync, blank}), 32'({24'd0, 3'b111}));
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      check("post_rst_hold", 32'({blue, green, red, hsync, vsync, blank}), 32'({24'd0, 3'b111}));
    end

    init_src();
    run(LAT + 4 * 800);

    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int k = 1; k <= 1024; k++) drive(k == 1, 1'b1, 24'(k));
    drive(1'b1, 1'b1, 24'h0);
    drive(1'b0, 1'b0, 24'h0);
    @(negedge clk);
    check("ls_beats_overflow", 32'(wr_overflow), 32'd0);
    for (int k = 1; k <= 1030; k++) begin
      drive(k == 1, 1'b1, 24'(k));
      @(negedge clk);
      if (k == 1025) check("ovf_after_1024", 32'(wr_overflow), 32'd0);
      if (k == 1026) check("ovf_after_1025", 32'(wr_overflow), 32'd1);
    end
    drive(1'b1, 1'b0, 24'h0);
    drive(1'b0, 1'b0, 24'h0);
    @(negedge clk);
    check("ovf_sticky", 32'(wr_overflow), 32'd1);
    #1; rst = 1'b1; #1;
    check("ovf_rst_clear", 32'(wr_overflow), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
